background_drawer: RTL and testbench
====================================

Name: background_drawer

Overview:
- Raster-scan writer that repaints the playfield from the background ROM set into the VGA framebuffer.
- Generates the X/Y sweep that feeds the background pixel lookup and receives the 3-bit colour back.
- Realigns each colour with its coordinates across the ROM read latency and issues one VGA plot per pixel.
- Sits between the game-state FSM (start/done handshake) and the VGA adapter write port.

Parameters:
- WIDTH, 240, pixels per row.
- HEIGHT, 240, rows per frame; WIDTH*HEIGHT must fit the 16-bit ROM address.
- ROM_LATENCY, 1, clocks from X/Y valid to colour valid; legal values are 1 or 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to redraw; sampled only in IDLE.
- gameState  in  4  current game state; latched at start.
- bg_gameState  out  4  frozen state driven to the pixel lookup for the whole frame.
- X  out  9  scan column to the pixel lookup.
- Y  out  8  scan row to the pixel lookup.
- color_in  in  3  colour returned by the lookup, valid ROM_LATENCY clocks after X/Y.
- vga_x  out  9  plot column.
- vga_y  out  8  plot row.
- vga_colour  out  3  plot colour (equals color_in on the cycle vga_plot is high).
- vga_plot  out  1  framebuffer write enable, one pixel per high cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when the final pixel has been plotted.

Behaviour:
- Reset values: all outputs 0. State is IDLE and the coordinate/valid delay line is cleared, so no plot occurs after reset.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE: when start=1 at edge k:
  - latch gameState into bg_gameState;
  - load X=X0, Y=Y0;
  - busy=1;
  - enter SCAN.
  - start=0 leaves the block in IDLE.
- SCAN: one address per clock.
  - X increments each cycle.
  - At X=X0+W-1, X wraps to X0 and Y increments.
  - After the address (X0+W-1, Y0+H-1) has been presented, go to FLUSH.
  - X/Y hold their last value after the final address.
- Delay line: a ROM_LATENCY-deep shift of {valid, X, Y}. When a delayed valid is high, it drives vga_plot=1, vga_x/vga_y = delayed coordinates, and vga_colour = color_in.
- FLUSH: waits until the delay line is empty, so the last plot lands at cycle k+W*H+ROM_LATENCY.
- DONE: one cycle with done=1 and busy=0, then return to IDLE.
- Full frame (X0=Y0=0, W=WIDTH, H=HEIGHT): 57600 plots. The first plot is (0,0) at cycle k+1+ROM_LATENCY.
- Plot order: strictly row-major, with no gaps or duplicates; vga_plot is continuous during the frame.
- Changes to gameState while busy do not affect bg_gameState until the next start.
- start while busy or in DONE is ignored; it is neither queued nor a restart.
- Reset mid-frame abandons the frame immediately: no further plots and no done pulse.
- Arithmetic: coordinates use unsigned 9/8-bit registers, and counters compare against end values rather than relying on overflow.

Optional Feature:
- Macro: BACKGROUND_RECT_REDRAW_EN.
- Defined:
  - Adds input ports rect_x0 (9), rect_y0 (8), rect_w (9), rect_h (8).
  - These are latched at start and set X0, Y0, W, H; this lets bridge/pillar updates repaint only a sub-region.
  - rect_w=0 or rect_h=0: no plots; done pulses 2 cycles after start (SCAN skipped).
  - Rectangles extending past WIDTH/HEIGHT are clipped to the screen edge at latch time.
- Undefined: the ports are absent; X0=Y0=0, W=WIDTH, H=HEIGHT always.

Decomposition:
- Shared package holds:
  - gameState encodings (DRAW_INITIAL=0 … FINISHED_GAME=11);
  - 3-bit colour constants;
  - screen WIDTH/HEIGHT defaults;
  - the drawer state encoding.
- One sub-module, bg_plot_delay: a parameterised valid/X/Y shift register of depth ROM_LATENCY.

Test Plan:
- Reset, then start with gameState=3, ROM_LATENCY=1 → first plot (0,0) at k+2; exactly 57600 plots; last plot (239,239); done one cycle after last plot; bg_gameState=3 throughout.
- Model ROM returning colour=(X+Y)%8 with 1- and 2-cycle latency → every vga_colour equals (vga_x+vga_y)%8; no coordinate is written twice.
- Change gameState 1→5 and pulse start at plot 1000 → bg_gameState stays 1; plot count unchanged; no restart.
- Assert reset at plot 30000 → vga_plot, busy, done drop next cycle; a subsequent start produces a full clean frame.
- RECT_REDRAW_EN, rect (100,50,20,10) → 200 plots covering x 100..119, y 50..59 in row-major order; then rect_w=0 → zero plots, done at k+2.
- rect (230,235,20,10) with macro defined → clipped to 10×5 = 50 plots; max vga_x=239, max vga_y=239.

Source files
------------

// File: rtl/background_drawer_pkg.sv
// Shared constants for the background drawer: game-state codes, palette, screen size, FSM states.
package background_drawer_pkg;

    localparam int unsigned SCREEN_WIDTH  = 240;
    localparam int unsigned SCREEN_HEIGHT = 240;

    localparam logic [3:0] DRAW_INITIAL  = 4'd0;
    localparam logic [3:0] WAIT_START    = 4'd1;
    localparam logic [3:0] BUILD_BRIDGE  = 4'd2;
    localparam logic [3:0] ROTATE_BRIDGE = 4'd3;
    localparam logic [3:0] CHECK_BRIDGE  = 4'd4;
    localparam logic [3:0] WALK_PLAYER   = 4'd5;
    localparam logic [3:0] FALL_PLAYER   = 4'd6;
    localparam logic [3:0] SCROLL_SCREEN = 4'd7;
    localparam logic [3:0] NEW_PILLAR    = 4'd8;
    localparam logic [3:0] UPDATE_SCORE  = 4'd9;
    localparam logic [3:0] GAME_OVER     = 4'd10;
    localparam logic [3:0] FINISHED_GAME = 4'd11;

    localparam logic [2:0] COLOUR_BLACK   = 3'd0;
    localparam logic [2:0] COLOUR_BLUE    = 3'd1;
    localparam logic [2:0] COLOUR_GREEN   = 3'd2;
    localparam logic [2:0] COLOUR_CYAN    = 3'd3;
    localparam logic [2:0] COLOUR_RED     = 3'd4;
    localparam logic [2:0] COLOUR_MAGENTA = 3'd5;
    localparam logic [2:0] COLOUR_YELLOW  = 3'd6;
    localparam logic [2:0] COLOUR_WHITE   = 3'd7;

    typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} drawer_state_e;

    // Length of a span starting at origin, clipped so it ends at or before limit-1.
    function automatic logic [9:0] clip_len(input logic [9:0] origin, input logic [9:0] len,
                                            input logic [9:0] limit);
        logic [9:0] avail;
        avail = limit - origin;
        if (origin >= limit) begin
            return '0;
        end
        return (len > avail) ? avail : len;
    endfunction

endpackage

// File: rtl/background_drawer_plot_delay.sv
// bg_plot_delay: shifts {valid, x, y} by Depth clocks to line coordinates up with ROM colour.
module bg_plot_delay #(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [8:0] x_i,
    input  logic [7:0] y_i,
    output logic       valid_o,
    output logic [8:0] x_o,
    output logic [7:0] y_o,
    output logic       pending_o
);

    logic [Depth-1:0] valid_q;
    logic [8:0]       x_q [Depth];
    logic [7:0]       y_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            x_q[0]     <= x_i;
            y_q[0]     <= y_i;
            for (int i = 1; i < int'(Depth); i++) begin
                valid_q[i] <= valid_q[i-1];
                x_q[i]     <= x_q[i-1];
                y_q[i]     <= y_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign x_o     = x_q[Depth-1];
    assign y_o     = y_q[Depth-1];

    // Pixels still in flight behind the one currently at the output.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < int'(Depth) - 1; i++) begin
            pending_o = pending_o | valid_q[i];
        end
    end

endmodule

// File: rtl/background_drawer.sv
// Raster-scan background repaint into the VGA framebuffer.
// Define BACKGROUND_RECT_REDRAW_EN to add rect_* ports for sub-region repaints.
module background_drawer
    import background_drawer_pkg::*;
#(
    parameter int unsigned WIDTH       = SCREEN_WIDTH,
    parameter int unsigned HEIGHT      = SCREEN_HEIGHT,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] gameState,
`ifdef BACKGROUND_RECT_REDRAW_EN
    input  logic [8:0] rect_x0,
    input  logic [7:0] rect_y0,
    input  logic [8:0] rect_w,
    input  logic [7:0] rect_h,
`endif
    output logic [3:0] bg_gameState,
    output logic [8:0] X,
    output logic [7:0] Y,
    input  logic [2:0] color_in,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    drawer_state_e state_q, state_d;
    logic [3:0]    gs_q, gs_d;
    logic [8:0]    x_q, x_d, x0_q, x0_d, xend_q, xend_d;
    logic [7:0]    y_q, y_d, yend_q, yend_d;

    logic [8:0] org_x;
    logic [7:0] org_y;
    logic [9:0] len_x;
    logic [8:0] len_y;
    logic       rect_empty;

    logic       d_valid, d_pending;
    logic [8:0] d_x;
    logic [7:0] d_y;

    // Rectangle as it would be latched on an accepted start.
    always_comb begin
`ifdef BACKGROUND_RECT_REDRAW_EN
        org_x = rect_x0;
        org_y = rect_y0;
        len_x = clip_len(10'(rect_x0), 10'(rect_w), 10'(WIDTH));
        len_y = 9'(clip_len(10'(rect_y0), 10'(rect_h), 10'(HEIGHT)));
`else
        org_x = '0;
        org_y = '0;
        len_x = 10'(WIDTH);
        len_y = 9'(HEIGHT);
`endif
        rect_empty = (len_x == '0) || (len_y == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            gs_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            xend_q  <= '0;
            yend_q  <= '0;
        end else begin
            state_q <= state_d;
            gs_q    <= gs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            xend_q  <= xend_d;
            yend_q  <= yend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gs_d    = gs_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        xend_d  = xend_q;
        yend_d  = yend_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gs_d    = gameState;
                    x_d     = org_x;
                    y_d     = org_y;
                    x0_d    = org_x;
                    xend_d  = 9'(10'(org_x) + len_x - 10'd1);
                    yend_d  = 8'(9'(org_y) + len_y - 9'd1);
                    state_d = rect_empty ? StFlush : StScan;
                end
            end
            StScan: begin
                if (x_q != xend_q) begin
                    x_d = x_q + 9'd1;
                end else if (y_q != yend_q) begin
                    x_d = x0_q;
                    y_d = y_q + 8'd1;
                end else begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!d_pending) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    bg_plot_delay #(
        .Depth(ROM_LATENCY)
    ) u_delay (
        .clk_i    (clock),
        .rst_i    (reset),
        .valid_i  (state_q == StScan),
        .x_i      (x_q),
        .y_i      (y_q),
        .valid_o  (d_valid),
        .x_o      (d_x),
        .y_o      (d_y),
        .pending_o(d_pending)
    );

    assign bg_gameState = gs_q;
    assign X            = x_q;
    assign Y            = y_q;
    assign vga_plot     = d_valid;
    assign vga_x        = d_valid ? d_x : '0;
    assign vga_y        = d_valid ? d_y : '0;
    assign vga_colour   = d_valid ? color_in : '0;
    assign busy         = (state_q == StScan) || (state_q == StFlush);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_background_drawer.sv
// Directed bench: full 240x240 frame at latency 1, a 16x8 instance at latency 2.
module tb_background_drawer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Full-size instance, ROM latency 1
    logic       reset_f, start_f;
    logic [3:0] gs_f, bg_f;
    logic [8:0] x_f, vx_f;
    logic [7:0] y_f, vy_f;
    logic [2:0] color_f, vc_f, rom_f;
    logic       plot_f, busy_f, done_f;
`ifdef BACKGROUND_RECT_REDRAW_EN
    logic [8:0] rx0_f, rw_f;
    logic [7:0] ry0_f, rh_f;
`endif

    // Small instance, ROM latency 2
    logic       reset_s, start_s;
    logic [3:0] gs_s, bg_s;
    logic [8:0] x_s, vx_s;
    logic [7:0] y_s, vy_s;
    logic [2:0] color_s, vc_s, rom1_s, rom2_s;
    logic       plot_s, busy_s, done_s;

    always @(posedge clock) rom_f <= 3'(10'(x_f) + 10'(y_f));
    always @(posedge clock) begin
        rom1_s <= 3'(10'(x_s) + 10'(y_s));
        rom2_s <= rom1_s;
    end
    assign color_f = rom_f;
    assign color_s = rom2_s;

    background_drawer u_full (
        .clock       (clock),
        .reset       (reset_f),
        .start       (start_f),
        .gameState   (gs_f),
`ifdef BACKGROUND_RECT_REDRAW_EN
        .rect_x0     (rx0_f),
        .rect_y0     (ry0_f),
        .rect_w      (rw_f),
        .rect_h      (rh_f),
`endif
        .bg_gameState(bg_f),
        .X           (x_f),
        .Y           (y_f),
        .color_in    (color_f),
        .vga_x       (vx_f),
        .vga_y       (vy_f),
        .vga_colour  (vc_f),
        .vga_plot    (plot_f),
        .busy        (busy_f),
        .done        (done_f)
    );

    background_drawer #(
        .WIDTH      (16),
        .HEIGHT     (8),
        .ROM_LATENCY(2)
    ) u_small (
        .clock       (clock),
        .reset       (reset_s),
        .start       (start_s),
        .gameState   (gs_s),
`ifdef BACKGROUND_RECT_REDRAW_EN
        .rect_x0     (9'd0),
        .rect_y0     (8'd0),
        .rect_w      (9'd16),
        .rect_h      (8'd8),
`endif
        .bg_gameState(bg_s),
        .X           (x_s),
        .Y           (y_s),
        .color_in    (color_s),
        .vga_x       (vx_s),
        .vga_y       (vy_s),
        .vga_colour  (vc_s),
        .vga_plot    (plot_s),
        .busy        (busy_s),
        .done        (done_s)
    );

    // Plot monitors: count, order against expected row-major walk, colour, done
    int pcnt_f, first_f, last_f, lastx_f, lasty_f, maxx_f, maxy_f;
    int colerr_f, orderr_f, gserr_f, dcnt_f, dcyc_f, ex_f, ey_f, ex0_f, exend_f;
    logic [3:0] egs_f;
    int pcnt_s, first_s, last_s, lastx_s, lasty_s;
    int colerr_s, orderr_s, gserr_s, dcnt_s, dcyc_s, ex_s, ey_s, exend_s;
    logic [3:0] egs_s;

    always @(negedge clock) begin
        if (plot_f) begin
            pcnt_f++;
            if (pcnt_f == 1) first_f = cyc;
            last_f = cyc; lastx_f = int'(vx_f); lasty_f = int'(vy_f);
            if (int'(vx_f) > maxx_f) maxx_f = int'(vx_f);
            if (int'(vy_f) > maxy_f) maxy_f = int'(vy_f);
            if (vc_f !== 3'(10'(vx_f) + 10'(vy_f))) colerr_f++;
            if (int'(vx_f) != ex_f || int'(vy_f) != ey_f) orderr_f++;
            if (ex_f == exend_f) begin ex_f = ex0_f; ey_f++; end
            else ex_f++;
        end
        if (done_f) begin dcnt_f++; dcyc_f = cyc; end
        if (busy_f && bg_f !== egs_f) gserr_f++;
    end

    always @(negedge clock) begin
        if (plot_s) begin
            pcnt_s++;
            if (pcnt_s == 1) first_s = cyc;
            last_s = cyc; lastx_s = int'(vx_s); lasty_s = int'(vy_s);
            if (vc_s !== 3'(10'(vx_s) + 10'(vy_s))) colerr_s++;
            if (int'(vx_s) != ex_s || int'(vy_s) != ey_s) orderr_s++;
            if (ex_s == exend_s) begin ex_s = 0; ey_s++; end
            else ex_s++;
        end
        if (done_s) begin dcnt_s++; dcyc_s = cyc; end
        if (busy_s && bg_s !== egs_s) gserr_s++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic arm_f(input int x0, input int y0, input int xe, input logic [3:0] gs);
        pcnt_f = 0; first_f = -1; last_f = -1; lastx_f = -1; lasty_f = -1;
        maxx_f = -1; maxy_f = -1; colerr_f = 0; orderr_f = 0; gserr_f = 0;
        dcnt_f = 0; dcyc_f = -1; ex_f = x0; ey_f = y0; ex0_f = x0; exend_f = xe; egs_f = gs;
    endtask

    task automatic arm_s(input logic [3:0] gs);
        pcnt_s = 0; first_s = -1; last_s = -1; lastx_s = -1; lasty_s = -1;
        colerr_s = 0; orderr_s = 0; gserr_s = 0; dcnt_s = 0; dcyc_s = -1;
        ex_s = 0; ey_s = 0; exend_s = 15; egs_s = gs;
    endtask

    task automatic start_full(input logic [3:0] gs, output int k0);
        gs_f = gs; start_f = 1'b1; k0 = cyc;
        tick(1);
        start_f = 1'b0;
    endtask

    task automatic start_small(input logic [3:0] gs, output int k0);
        gs_s = gs; start_s = 1'b1; k0 = cyc;
        tick(1);
        start_s = 1'b0;
    endtask

    task automatic wait_done_f(input int bound);
        int n = 0;
        while (dcnt_f == 0 && n < bound) begin tick(1); n++; end
    endtask

    task automatic wait_done_s(input int bound);
        int n = 0;
        while (dcnt_s == 0 && n < bound) begin tick(1); n++; end
    endtask

    initial begin
        int k0, n;
        bit mid;
        reset_f = 1'b1; start_f = 1'b0; gs_f = 4'd9;
        reset_s = 1'b1; start_s = 1'b0; gs_s = 4'd9;
`ifdef BACKGROUND_RECT_REDRAW_EN
        rx0_f = 9'd0; ry0_f = 8'd0; rw_f = 9'd240; rh_f = 8'd240;
`endif
        arm_f(0, 0, 239, 4'd0);
        arm_s(4'd0);
        tick(3);
        check("f reset xy", int'({x_f, y_f}), 0);
        check("f reset outs", int'({vx_f, vy_f, vc_f, plot_f, busy_f, done_f, bg_f}), 0);
        check("s reset xy", int'({x_s, y_s}), 0);
        check("s reset outs", int'({vx_s, vy_s, vc_s, plot_s, busy_s, done_s, bg_s}), 0);
        reset_f = 1'b0; reset_s = 1'b0;
        tick(2);
        check("s no plot after reset", pcnt_s, 0);

        // Small frame, latency 2
        arm_s(4'd6);
        start_small(4'd6, k0);
        gs_s = 4'd1;
        check("s busy after start", int'(busy_s), 1);
        wait_done_s(400);
        check("s done count", dcnt_s, 1);
        check("s plots", pcnt_s, 128);
        check("s first plot cyc", first_s, k0 + 3);
        check("s last plot cyc", last_s, k0 + 130);
        check("s done cyc", dcyc_s, k0 + 131);
        check("s last x", lastx_s, 15);
        check("s last y", lasty_s, 7);
        check("s colour errs", colerr_s, 0);
        check("s order errs", orderr_s, 0);
        check("s bg state errs", gserr_s, 0);
        tick(1);
        check("s busy after done", int'({busy_s, done_s}), 0);

        // Reset mid-frame
        arm_s(4'd2);
        start_small(4'd2, k0);
        n = 0;
        while (pcnt_s < 60 && n < 500) begin tick(1); n++; end
        reset_s = 1'b1;
        tick(1);
        check("s reset drops outs", int'({plot_s, busy_s, done_s}), 0);
        check("s reset clears xy", int'({x_s, y_s}), 0);
        reset_s = 1'b0;
        tick(10);
        check("s plots at abort", pcnt_s, 61);
        check("s no done after abort", dcnt_s, 0);

        // Clean frame after abort
        arm_s(4'd10);
        start_small(4'd10, k0);
        wait_done_s(400);
        check("s2 done count", dcnt_s, 1);
        check("s2 plots", pcnt_s, 128);
        check("s2 first plot cyc", first_s, k0 + 3);
        check("s2 order errs", orderr_s, 0);
        check("s2 colour errs", colerr_s, 0);
        check("s2 bg state", int'(bg_s), 10);

        // Full frame, latency 1; gameState change and start pulse at plot 1000
        arm_f(0, 0, 239, 4'd3);
        start_full(4'd3, k0);
        check("f busy after start", int'(busy_f), 1);
        n = 0; mid = 1'b0;
        while (dcnt_f == 0 && n < 60000) begin
            if (!mid && pcnt_f >= 1000) begin
                gs_f = 4'd5; start_f = 1'b1; mid = 1'b1;
                tick(1);
                start_f = 1'b0;
            end else begin
                tick(1);
            end
            n++;
        end
        check("f done count", dcnt_f, 1);
        check("f plots", pcnt_f, 57600);
        check("f first plot cyc", first_f, k0 + 2);
        check("f last plot cyc", last_f, k0 + 57601);
        check("f done cyc", dcyc_f, k0 + 57602);
        check("f last x", lastx_f, 239);
        check("f last y", lasty_f, 239);
        check("f colour errs", colerr_f, 0);
        check("f order errs", orderr_f, 0);
        check("f bg state errs", gserr_f, 0);
        tick(5);
        check("f no restart plots", pcnt_f, 57600);
        check("f idle after frame", int'({busy_f, done_f}), 0);
        check("f bg state held", int'(bg_f), 3);

`ifdef BACKGROUND_RECT_REDRAW_EN
        rx0_f = 9'd100; ry0_f = 8'd50; rw_f = 9'd20; rh_f = 8'd10;
        arm_f(100, 50, 119, 4'd7);
        start_full(4'd7, k0);
        wait_done_f(400);
        check("r plots", pcnt_f, 200);
        check("r first plot cyc", first_f, k0 + 2);
        check("r done cyc", dcyc_f, k0 + 202);
        check("r last x", lastx_f, 119);
        check("r last y", lasty_f, 59);
        check("r order errs", orderr_f, 0);
        check("r colour errs", colerr_f, 0);

        rw_f = 9'd0;
        arm_f(100, 50, 119, 4'd8);
        start_full(4'd8, k0);
        wait_done_f(20);
        check("r0 plots", pcnt_f, 0);
        check("r0 done cyc", dcyc_f, k0 + 2);

        rx0_f = 9'd230; ry0_f = 8'd235; rw_f = 9'd20; rh_f = 8'd10;
        arm_f(230, 235, 239, 4'd4);
        start_full(4'd4, k0);
        wait_done_f(200);
        check("rc plots", pcnt_f, 50);
        check("rc max x", maxx_f, 239);
        check("rc max y", maxy_f, 239);
        check("rc order errs", orderr_f, 0);
        check("rc done count", dcnt_f, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
